mdio_master: RTL and testbench

//  Clause-22 MDIO management master: serialises PHY register requests from the PHY configuration stage onto MDC/MDIO.

---
 rtl/mdio_pkg.sv | 28 ++
 rtl/mdio_clk_div.sv | 50 +++++
 rtl/mdio_master.sv | 175 +++++++++++++++++
 tb/tb_mdio_master.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Clause-22 MDIO frame constants and master FSM state type.
package mdio_pkg;

  localparam int unsigned PhyAddW = 5;
  localparam int unsigned RegAddW = 5;
  localparam int unsigned DataW   = 16;
  localparam int unsigned FrameW  = 32;

  localparam logic [1:0] StartCode = 2'b01;
  localparam logic [1:0] OpWrite   = 2'b01;
  localparam logic [1:0] OpRead    = 2'b10;
  localparam logic [1:0] TaWrite   = 2'b10;
  // Read frames leave TA/DATA undriven; the shift register carries idle ones there.
  localparam logic [1:0] TaRead    = 2'b11;

  // Bit positions within the 32-bit ST..DATA frame.
  localparam logic [5:0] BitTaFirst   = 6'd14;
  localparam logic [5:0] BitDataFirst = 6'd16;
  localparam logic [5:0] BitFrameLast = 6'd31;

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StShift,
    StGap
  } mdio_state_e;

endpackage

// File: rtl/mdio_clk_div.sv
// MDC generator: free-running divider with single-cycle rise/fall strobes and a
// synchronous clear used to phase-align MDC to the accepted request.
module mdio_clk_div #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mdc_q, mdc_d;
  logic            wrap;

  always_comb begin
    wrap  = en_i && !clr_i && (cnt_q == CntLast);
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (clr_i) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (en_i) begin
      cnt_d = wrap ? '0 : cnt_q + CntW'(1);
      mdc_d = wrap ? ~mdc_q : mdc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  // Strobes mark the clk cycle at whose end MDC changes level.
  assign mdc_o  = mdc_q;
  assign rise_o = wrap && !mdc_q;
  assign fall_o = wrap && mdc_q;

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master. Define MDIO_READ_EN to enable register reads
// (rden, read turnaround and rd_data/rd_valid); otherwise every frame is a write.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 13,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PhyAddW-1:0] phy_add,
  input  logic [RegAddW-1:0] reg_add,
  input  logic [DataW-1:0]   wr_data,
  input  logic               wren,
  input  logic               rden,
  output logic               busy,
  output logic [DataW-1:0]   rd_data,
  output logic               rd_valid,
  output logic               mdc,
  output logic               mdio_o,
  output logic               mdio_oe,
  input  logic               mdio_i
);

  localparam logic [5:0] PreLast = (PRE_LEN == 0) ? 6'd0 : 6'(PRE_LEN - 1);

  mdio_state_e       state_q, state_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [FrameW-1:0] sh_q, sh_d;
  logic              mdio_o_q, mdio_o_d;
  logic              mdio_oe_q, mdio_oe_d;
  logic              is_rd_q, is_rd_d;
  logic [DataW-1:0]  rd_sh_q, rd_sh_d;
  logic [DataW-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              req_rd, rd_op, accept, rd_in;
  logic              mdc_rise, mdc_fall;
  logic [FrameW-1:0] frame;

`ifdef MDIO_READ_EN
  assign req_rd   = rden;
  assign rd_in    = mdio_i;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_rd;
  assign req_rd    = 1'b0;
  assign rd_in     = 1'b0;
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
  assign unused_rd = ^{mdio_i, rden, rd_data_q, rd_valid_q};
`endif

  assign accept = (state_q == StIdle) && (wren || req_rd);
  assign rd_op  = req_rd && !wren;
  assign frame  = {StartCode, rd_op ? OpRead : OpWrite, phy_add, reg_add,
                   rd_op ? TaRead : TaWrite, rd_op ? {DataW{1'b1}} : wr_data};

  mdio_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (state_q != StIdle),
    .mdc_o  (mdc),
    .rise_o (mdc_rise),
    .fall_o (mdc_fall)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    mdio_o_d   = mdio_o_q;
    mdio_oe_d  = mdio_oe_q;
    is_rd_d    = is_rd_q;
    rd_sh_d    = rd_sh_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          is_rd_d   = rd_op;
          bit_cnt_d = '0;
          mdio_oe_d = 1'b1;
          if (PRE_LEN == 0) begin
            state_d  = StShift;
            mdio_o_d = frame[FrameW-1];
            sh_d     = {frame[FrameW-2:0], 1'b1};
          end else begin
            state_d  = StPre;
            mdio_o_d = 1'b1;
            sh_d     = frame;
          end
        end
      end
      StPre: begin
        if (mdc_fall) begin
          if (bit_cnt_q == PreLast) begin
            state_d   = StShift;
            bit_cnt_d = '0;
            mdio_o_d  = sh_q[FrameW-1];
            sh_d      = {sh_q[FrameW-2:0], 1'b1};
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      StShift: begin
        if (mdc_rise && is_rd_q && (bit_cnt_q >= BitDataFirst)) begin
          rd_sh_d = {rd_sh_q[DataW-2:0], rd_in};
        end
        if (mdc_fall) begin
          if (bit_cnt_q == BitFrameLast) begin
            state_d   = StGap;
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            mdio_o_d  = sh_q[FrameW-1];
            sh_d      = {sh_q[FrameW-2:0], 1'b1};
            // Release the line from the first turnaround bit onward.
            if (is_rd_q && (bit_cnt_q + 6'd1 >= BitTaFirst)) begin
              mdio_oe_d = 1'b0;
            end
          end
        end
      end
      StGap: begin
        if (mdc_fall) begin
          state_d   = StIdle;
          mdio_o_d  = 1'b1;
          mdio_oe_d = 1'b0;
          if (is_rd_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_sh_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      mdio_o_q   <= 1'b1;
      mdio_oe_q  <= 1'b0;
      is_rd_q    <= 1'b0;
      rd_sh_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      mdio_o_q   <= mdio_o_d;
      mdio_oe_q  <= mdio_oe_d;
      is_rd_q    <= is_rd_d;
      rd_sh_q    <= rd_sh_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign mdio_o  = mdio_o_q;
  assign mdio_oe = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: per-MDC-rise scoreboard of {oe, data},
// busy length, read capture, drop-while-busy, mid-frame reset, fast configuration.
module tb_mdio_master;

  localparam int CD    = 13;
  localparam int PL    = 32;
  localparam int FCD   = 2;
  localparam int FPL   = 0;
  localparam int Bound = 5000;

  logic        clk;
  logic        rst_n;
  logic [4:0]  phy_add, reg_add;
  logic [15:0] wr_data;
  logic        wren, rden;
  logic        busy, rd_valid, mdc, mdio_o, mdio_oe, mdio_i;
  logic [15:0] rd_data;

  logic        f_wren, f_rden;
  logic        f_busy, f_rd_valid, f_mdc, f_mdio_o, f_mdio_oe, f_mdio_i;
  logic [15:0] f_rd_data;

  int          total, bad, cyc, rv_cnt;
  logic [15:0] rv_data;
  logic [15:0] phy_word;
  logic [1:0]  exp_q[$];
  logic [1:0]  f_exp_q[$];
  int          f_rise_t[$];

  assign f_mdio_i = 1'b1;

  mdio_master #(
    .CLK_DIV (CD),
    .PRE_LEN (PL)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .phy_add  (phy_add),
    .reg_add  (reg_add),
    .wr_data  (wr_data),
    .wren     (wren),
    .rden     (rden),
    .busy     (busy),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .mdc      (mdc),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe),
    .mdio_i   (mdio_i)
  );

  mdio_master #(
    .CLK_DIV (FCD),
    .PRE_LEN (FPL)
  ) u_dut_fast (
    .clk      (clk),
    .rst_n    (rst_n),
    .phy_add  (phy_add),
    .reg_add  (reg_add),
    .wr_data  (wr_data),
    .wren     (f_wren),
    .rden     (f_rden),
    .busy     (f_busy),
    .rd_data  (f_rd_data),
    .rd_valid (f_rd_valid),
    .mdc      (f_mdc),
    .mdio_o   (f_mdio_o),
    .mdio_oe  (f_mdio_oe),
    .mdio_i   (f_mdio_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {oe, data} at each MDC rise: preamble, ST..DATA, then the gap bit.
  task automatic push_frame(input bit fast, input int pre, input logic rd, input logic [4:0] p,
                            input logic [4:0] g, input logic [15:0] d);
    logic [31:0] fr;
    logic [1:0]  e;
    fr = {2'b01, rd ? 2'b10 : 2'b01, p, g, 2'b10, d};
    for (int i = 0; i < pre + 33; i++) begin
      if (i < pre)                        e = 2'b11;
      else if (i == pre + 32)             e = 2'b01;
      else if (rd && (i - pre) >= 14)     e = 2'b01;
      else                                e = {1'b1, fr[31 - (i - pre)]};
      if (fast) f_exp_q.push_back(e);
      else      exp_q.push_back(e);
    end
  endtask

  task automatic start_req(input logic w, input logic r, input logic [4:0] p,
                           input logic [4:0] g, input logic [15:0] d);
    logic rd_eff;
`ifdef MDIO_READ_EN
    rd_eff = r && !w;
`else
    rd_eff = 1'b0;
`endif
    phy_add = p;
    reg_add = g;
    wr_data = d;
    wren    = w;
    rden    = r;
    if (w || rd_eff) push_frame(1'b0, PL, rd_eff, p, g, d);
    @(negedge clk);
    wren = 1'b0;
    rden = 1'b0;
  endtask

  // Counts busy cycles; optionally fires stray wren pulses at given offsets.
  task automatic wait_idle(input int pa, input int pb, output int len);
    len = 0;
    while (busy && len < Bound) begin
      if (len == pa || len == pb) begin
        wren    = 1'b1;
        wr_data = 16'hFFFF;
      end else begin
        wren = 1'b0;
      end
      len++;
      @(negedge clk);
    end
    wren = 1'b0;
    check("busy_drop", 32'(busy), 32'd0);
  endtask

  // Main DUT monitor plus PHY read-data model.
  initial begin
    logic       mdc_prev;
    logic [1:0] e;
    int         rise_idx, idx;
    mdc_prev = 1'b0;
    rise_idx = 0;
    mdio_i   = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdc_prev = 1'b0;
        rise_idx = 0;
        mdio_i   = 1'b1;
      end else begin
        if (mdc && !mdc_prev) begin
          if (exp_q.size() == 0) begin
            check("extra_bit", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("bit", 32'({mdio_oe, mdio_oe ? mdio_o : 1'b1}), 32'(e));
          end
          rise_idx++;
          idx    = rise_idx - (PL + 16);
          mdio_i = (idx >= 0 && idx < 16) ? phy_word[15 - idx] : 1'b1;
        end
        if (!busy) rise_idx = 0;
        if (rd_valid) begin
          rv_cnt++;
          rv_data = rd_data;
          check("rv_busy", 32'(busy), 32'd0);
        end
        mdc_prev = mdc;
      end
    end
  end

  initial begin
    logic       f_mdc_prev;
    logic [1:0] e;
    f_mdc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        f_mdc_prev = 1'b0;
      end else begin
        if (f_mdc && !f_mdc_prev) begin
          f_rise_t.push_back(cyc);
          if (f_exp_q.size() == 0) begin
            check("f_extra_bit", 32'd1, 32'd0);
          end else begin
            e = f_exp_q.pop_front();
            check("f_bit", 32'({f_mdio_oe, f_mdio_oe ? f_mdio_o : 1'b1}), 32'(e));
          end
        end
        f_mdc_prev = f_mdc;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int len;
    total    = 0;
    bad      = 0;
    rv_cnt   = 0;
    rv_data  = '0;
    phy_word = 16'hBEEF;
    wren     = 1'b0;
    rden     = 1'b0;
    f_wren   = 1'b0;
    f_rden   = 1'b0;
    phy_add  = '0;
    reg_add  = '0;
    wr_data  = '0;
    rst_n    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_mdc", 32'(mdc), 32'd0);
    check("rst_mdio_o", 32'(mdio_o), 32'd1);
    check("rst_mdio_oe", 32'(mdio_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain write; busy spans PRE_LEN + 32 + 1 MDC periods.
    start_req(1'b1, 1'b0, 5'd0, 5'd0, 16'h3100);
    wait_idle(-1, -1, len);
    check("t1_busy_len", 32'(len), 32'((PL + 33) * 2 * CD));
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Stray requests while busy are dropped.
    start_req(1'b1, 1'b0, 5'h1F, 5'h0A, 16'hA5C3);
    wait_idle(0, 99, len);
    check("t2_busy_len", 32'(len), 32'((PL + 33) * 2 * CD));
    repeat (200) @(negedge clk);
    check("t2_idle", 32'(busy), 32'd0);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef MDIO_READ_EN
    rv_cnt = 0;
    start_req(1'b0, 1'b1, 5'h01, 5'h02, 16'h0000);
    wait_idle(-1, -1, len);
    @(negedge clk);
    check("t3_busy_len", 32'(len), 32'((PL + 33) * 2 * CD));
    check("t3_rv_cnt", 32'(rv_cnt), 32'd1);
    check("t3_rv_data", 32'(rv_data), 32'h0000BEEF);
    check("t3_rd_data", 32'(rd_data), 32'h0000BEEF);
    check("t3_rv_pulse", 32'(rd_valid), 32'd0);
`else
    rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    repeat (5) @(negedge clk);
    check("t3_rden_ignored", 32'(busy), 32'd0);
    check("t3_rd_data", 32'(rd_data), 32'd0);
`endif

    // Simultaneous wren/rden: write wins.
    rv_cnt = 0;
    start_req(1'b1, 1'b1, 5'h03, 5'h04, 16'h1234);
    wait_idle(-1, -1, len);
    @(negedge clk);
    check("t4_busy_len", 32'(len), 32'((PL + 33) * 2 * CD));
    check("t4_rv_cnt", 32'(rv_cnt), 32'd0);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of the DATA field, MDC high.
    start_req(1'b1, 1'b0, 5'h02, 5'h03, 16'hC0DE);
    repeat ((PL + 20) * 2 * CD + CD + 2) @(negedge clk);
    check("t5_pre_mdc", 32'(mdc), 32'd1);
    check("t5_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_mdc", 32'(mdc), 32'd0);
    check("t5_mdio_oe", 32'(mdio_oe), 32'd0);
    check("t5_mdio_o", 32'(mdio_o), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_req(1'b1, 1'b0, 5'h07, 5'h11, 16'h5A0F);
    wait_idle(-1, -1, len);
    check("t5_busy_len", 32'(len), 32'((PL + 33) * 2 * CD));
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Fast instance: CLK_DIV=2, no preamble.
    f_rise_t.delete();
    phy_add = 5'h15;
    reg_add = 5'h0C;
    wr_data = 16'h8001;
    f_wren  = 1'b1;
    push_frame(1'b1, FPL, 1'b0, 5'h15, 5'h0C, 16'h8001);
    @(negedge clk);
    f_wren = 1'b0;
    len = 0;
    while (f_busy && len < Bound) begin
      len++;
      @(negedge clk);
    end
    check("t6_busy_drop", 32'(f_busy), 32'd0);
    check("t6_busy_len", 32'(len), 32'((FPL + 33) * 2 * FCD));
    check("t6_q_empty", 32'(f_exp_q.size()), 32'd0);
    if (f_rise_t.size() < 2) check("t6_rises", 32'(f_rise_t.size()), 32'd2);
    else check("t6_mdc_period", 32'(f_rise_t[1] - f_rise_t[0]), 32'(2 * FCD));

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
